ppu_depad: RTL

- Receive-side counterpart of the PPU symbol packer.
- Consumes the serial bit stream the PPU emits, one bit per valid cycle, each tagged with a 4-bit OFDM symbol number. Symbols are fixed-size frames of payload bits followed by pad bits.
- Strips the pad, checks symbol sequencing and frame length, and forwards payload bits with a one-cycle registered latency to the downstream deinterleaver/decoder input.

---
 rtl/ppu_depad.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ppu_depad.sv
// ppu_depad: strips symbol pad from the PPU serial stream and checks symbol sequencing.
// Optional PPU_DEPAD_PADCHK_EN adds a sticky pad_err flag for nonzero pad bits.
module ppu_depad #(
    parameter int SYM_BITS  = 576,
    parameter int DATA_BITS = 560,
    parameter int NUM_SYM   = 15,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       di,
    input  logic       di_vld,
    input  logic [3:0] di_sym_num,
    output logic       do_bit,
    output logic       do_vld,
    output logic [3:0] do_sym_num,
    output logic       frame_done,
`ifdef PPU_DEPAD_PADCHK_EN
    output logic       sym_err,
    output logic       pad_err
`else
    output logic       sym_err
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] PAD  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_SYM  = CNT_W'(SYM_BITS - 1);
    localparam logic [3:0]       LAST_NUM  = 4'(NUM_SYM - 1);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [3:0]       exp_sym;
    logic [3:0]       exp_n;
    logic             tag_ok;
    logic             fwd;
    logic             done_n;
    logic             err_set;
    logic             err_clr;
`ifdef PPU_DEPAD_PADCHK_EN
    logic             pad_set;
`endif

    assign tag_ok = (di_sym_num == exp_sym);

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        exp_n   = exp_sym;
        fwd     = 1'b0;
        done_n  = 1'b0;
        err_set = 1'b0;
        err_clr = 1'b0;
`ifdef PPU_DEPAD_PADCHK_EN
        pad_set = 1'b0;
`endif
        if (di_vld) begin
            unique case (state)
                IDLE: begin
                    // A frame may only open on symbol 0; anything else is dropped here.
                    if (di_sym_num == 4'd0) begin
                        err_clr = 1'b1;
                        exp_n   = 4'd0;
                        fwd     = 1'b1;
                        cnt_n   = CNT_W'(1);
                        state_n = (LAST_DATA == '0) ? PAD : DATA;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                DATA: begin
                    cnt_n = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_DATA) begin
                        state_n = PAD;
                    end
                    if (tag_ok) begin
                        fwd = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                PAD: begin
                    if (!tag_ok) begin
                        err_set = 1'b1;
                    end
`ifdef PPU_DEPAD_PADCHK_EN
                    pad_set = di;
`endif
                    if (bit_cnt == LAST_SYM) begin
                        cnt_n = '0;
                        if (exp_sym == LAST_NUM) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            exp_n   = exp_sym + 4'd1;
                            state_n = DATA;
                        end
                    end else begin
                        cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            exp_sym    <= 4'd0;
            do_bit     <= 1'b0;
            do_vld     <= 1'b0;
            do_sym_num <= 4'd0;
            frame_done <= 1'b0;
            sym_err    <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            exp_sym    <= exp_n;
            do_vld     <= fwd;
            frame_done <= done_n;
            if (fwd) begin
                do_bit     <= di;
                do_sym_num <= di_sym_num;
            end
            if (err_clr) begin
                sym_err <= 1'b0;
            end else if (err_set) begin
                sym_err <= 1'b1;
            end
        end
    end

`ifdef PPU_DEPAD_PADCHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pad_err <= 1'b0;
        end else if (err_clr) begin
            pad_err <= 1'b0;
        end else if (pad_set) begin
            pad_err <= 1'b1;
        end
    end
`endif

endmodule
